// File: rtl/cpu_types_pkg.sv
// Shared CPU/RAM types: word, RAM port state and arbiter state encodings.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  // Index width for n requesters; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester and RAM-side bus of the shared RAM port arbiter.
interface ram_arbiter_if
  import cpu_types_pkg::*;
#(
  parameter int unsigned REQS = 4
) ();

  logic  [REQS-1:0] req;
  logic  [REQS-1:0] wen;
  word_t [REQS-1:0] addr;
  word_t [REQS-1:0] wdata;
  logic  [REQS-1:0] gnt;
  logic  [REQS-1:0] done;
  logic             err;
  word_t            rdata;

  logic             ramREN;
  logic             ramWEN;
  word_t            ramaddr;
  word_t            ramstore;
  ramstate_t        ramstate;
  word_t            ramload;

  // Arbiter view.
  modport slave (
    input  req, wen, addr, wdata, ramstate, ramload,
    output gnt, done, err, rdata, ramREN, ramWEN, ramaddr, ramstore
  );

  // Requesters plus RAM view.
  modport master (
    output req, wen, addr, wdata, ramstate, ramload,
    input  gnt, done, err, rdata, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/ram_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit after ptr, with wrap.
module rr_pick
  import cpu_types_pkg::*;
#(
  parameter int unsigned REQS = 4,
  parameter int unsigned IW   = idx_width(REQS)
) (
  input  logic [REQS-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [REQS-1:0] win,
  output logic [IW-1:0]   win_idx
);

  // Scan ptr+1 .. ptr+REQS modulo REQS; REQS need not be a power of two.
  always_comb begin
    int unsigned j;
    logic        found;
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int unsigned k = 1; k <= REQS; k++) begin
      j = (32'(ptr) + k) % REQS;
      if (!found && req[IW'(j)]) begin
        found          = 1'b1;
        win[IW'(j)]    = 1'b1;
        win_idx        = IW'(j);
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin owner of the single shared RAM port (icache/dcache of each core).
// Optional watchdog: define RAM_ARB_WATCHDOG_EN to time out ISSUE after WD_CYCLES.
module ram_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned REQS      = 4,
  parameter int unsigned WD_CYCLES = 64
) (
  input logic          CLK,
  input logic          RST,
  ram_arbiter_if.slave bus
);

  localparam int unsigned IW = idx_width(REQS);

  arb_state_t      state, next_state;
  logic [REQS-1:0] gnt_q, done_q, pick;
  logic [IW-1:0]   gidx, ptr, pick_idx;
  logic            err_q;
  word_t           rdata_q;
  logic            own_req_c, own_wen_c, complete_c, timeout_c;

  rr_pick #(.REQS(REQS), .IW(IW)) u_pick (
    .req     (bus.req),
    .ptr     (ptr),
    .win     (pick),
    .win_idx (pick_idx)
  );

  assign own_req_c  = bus.req[gidx];
  assign own_wen_c  = bus.wen[gidx];
  assign complete_c = (bus.ramstate == ACCESS) || (bus.ramstate == ERROR) || timeout_c;

`ifdef RAM_ARB_WATCHDOG_EN
  localparam int unsigned WDW = $clog2(WD_CYCLES + 1);
  logic [WDW-1:0] wd_cnt;
  logic           ram_wait_c;

  assign ram_wait_c = (bus.ramstate == FREE) || (bus.ramstate == BUSY);

  // Counts ISSUE cycles spent waiting on the RAM; restarts on every ISSUE entry.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                 wd_cnt <= '0;
    else if (state != ISSUE) wd_cnt <= '0;
    else if (ram_wait_c)     wd_cnt <= wd_cnt + WDW'(1);
  end

  assign timeout_c = (state == ISSUE) && ram_wait_c && (wd_cnt == WDW'(WD_CYCLES - 1));
`else
  // Watchdog compiled out: WD_CYCLES has no effect and ISSUE never times out.
  assign timeout_c = (WD_CYCLES == 0) & 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state: grant, wait for RAM (or abort on dropped req), one response cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (|bus.req) next_state = ISSUE;
      ISSUE: begin
        if (!own_req_c)      next_state = IDLE;
        else if (complete_c) next_state = RESP;
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // RAM strobes and bus follow the current owner only while in ISSUE.
  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    if (state == ISSUE) begin
      bus.ramREN   = own_req_c & ~own_wen_c;
      bus.ramWEN   = own_req_c & own_wen_c;
      bus.ramaddr  = bus.addr[gidx];
      bus.ramstore = bus.wdata[gidx];
    end
  end

  // Grant, completion pulse, response data and fairness pointer.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      gnt_q   <= '0;
      gidx    <= '0;
      ptr     <= IW'(REQS - 1);
      done_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      done_q <= '0;
      case (state)
        IDLE: begin
          if (|bus.req) begin
            gnt_q <= pick;
            gidx  <= pick_idx;
          end
        end
        ISSUE: begin
          if (!own_req_c) begin
            gnt_q <= '0;
          end else if (bus.ramstate == ACCESS) begin
            rdata_q <= bus.ramload;
            err_q   <= 1'b0;
            done_q  <= gnt_q;
          end else if (complete_c) begin
            err_q  <= 1'b1;
            done_q <= gnt_q;
          end
        end
        RESP: begin
          ptr   <= gidx;
          gnt_q <= '0;
        end
        default: gnt_q <= '0;
      endcase
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.done  = done_q;
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Round-robin arbiter and sequencer for the single shared RAM port. It sits between the per-core cache request ports (icache and dcache of every core) and the RAM. It grants one requester at a time, holds that grant until the RAM completes the access, returns the read data with a one-cycle done pulse, and advances the fairness pointer. It replaces ad-hoc per-state RAM muxing with one owner of `ramREN`/`ramWEN`/`ramaddr`/`ramstore`.

## Interface

Clock is `CLK`. Reset `RST` is asynchronous and active-high.

Parameters:
- `REQS`, default 4: number of requesters. Index 2c is the icache of core c; index 2c+1 is its dcache.
- `WD_CYCLES`, default 64: watchdog limit in cycles. Used only with `RAM_ARB_WATCHDOG_EN`.

Ports:
- `CLK`  in  1  system clock.
- `RST`  in  1  asynchronous active-high reset.
- `req`  in  REQS  per-requester access request; held high until `done`.
- `wen`  in  REQS  1 = write, 0 = read; stable while `req` is high.
- `addr`  in  REQS×32  word address (`word_t`).
- `wdata`  in  REQS×32  store data.
- `gnt`  out  REQS  one-hot current owner; all zeros when idle.
- `done`  out  REQS  one-hot, one-cycle completion pulse.
- `err`  out  1  valid with `done`; 1 = RAM ERROR or watchdog timeout.
- `rdata`  out  32  registered `ramload`; valid with `done` on reads.
- `ramREN`, `ramWEN`  out  1  RAM strobes.
- `ramaddr`, `ramstore`  out  32  RAM address and store data.
- `ramstate`  in  `ramstate_t`  FREE/BUSY/ACCESS/ERROR.
- `ramload`  in  32  RAM read data.

## Operation

States (`arb_state_t`): IDLE, ISSUE, RESP.

- **IDLE**
  - RAM strobes are 0; `gnt` = 0.
  - If any `req` bit is set: pick the winner by round-robin, searching from `ptr+1` mod REQS upward with wrap-around.
  - Register the one-hot winner into `gnt`, then go to ISSUE.
- **ISSUE**
  - `ramREN = req[g] & ~wen[g]`; `ramWEN = req[g] & wen[g]`.
  - `ramaddr = addr[g]`; `ramstore = wdata[g]`.
  - `ramstate` ACCESS: capture `ramload` into `rdata`, set `err` = 0, go to RESP.
  - `ramstate` ERROR: set `err` = 1, go to RESP.
  - `ramstate` FREE or BUSY: stay in ISSUE.
  - If `req[g]` drops while in ISSUE: abort to IDLE. There is no `done` pulse and `ptr` is unchanged.
- **RESP**
  - `done` = `gnt`, high for exactly one cycle.
  - RAM strobes are 0.
  - Set `ptr` to g, then go to IDLE. `gnt` clears on entry to IDLE.
- **Requester rule:** deassert `req` at the clock edge that samples `done`. A `req` still high in the following IDLE cycle is a new request.
- **Simultaneous requests:** resolved only by the round-robin order; there is no i/d priority. The winner is never re-granted before every other pending requester has been served once.

## Timing

- Reset values: `gnt` = 0, `done` = 0, `err` = 0, `rdata` = 0, all RAM outputs 0, state IDLE, `ptr` = REQS−1 (requester 0 wins first).
- Reset asserted mid-access: everything returns to the reset values immediately. The in-flight access is dropped and no `done` is issued.
- Minimum latency: `req` seen in cycle 0 (IDLE), ISSUE in cycle 1 with ACCESS, `done` in cycle 2. Each RAM wait cycle adds one cycle.
- Back-to-back grants are separated by one RESP cycle and one IDLE cycle.
- Index width is `$clog2(REQS)`. The `ptr+1` wrap is computed modulo REQS; REQS need not be a power of two.

## Configuration

- `RAM_ARB_WATCHDOG_EN` defined:
  - A counter of width `$clog2(WD_CYCLES+1)` clears on entry to ISSUE and increments each ISSUE cycle without ACCESS or ERROR.
  - When the count reaches WD_CYCLES, go to RESP with `err` = 1.
  - `rdata` is unchanged on timeout.
- `RAM_ARB_WATCHDOG_EN` undefined: no counter. ISSUE waits indefinitely, and `err` comes only from ERROR.

## Structure

- `cpu_types_pkg` holds:
  - `arb_state_t` (2-bit enum).
  - The existing `ramstate_t` and `word_t`.
- Sub-module `rr_pick`: combinational round-robin one-hot picker. Inputs `req` and `ptr`; outputs one-hot winner and its index.

## Test plan

- Single read: `req[1]` with `addr=0x40`, RAM in ACCESS with `ramload=0xDEADBEEF` → `gnt=0010` in cycle 1, `done=0010` and `rdata=0xDEADBEEF` in cycle 2.
- All four `req` held continuously → grant order 0,1,2,3,0; each grant follows the previous `done` by 2 cycles.
- Write to a 3-cycle-BUSY RAM: `req[3]`, `wen=1`, `wdata=0x12345678`, `addr=0x80` → `ramWEN`, `ramaddr`, `ramstore` stable for 4 ISSUE cycles; `done=1000`, `err=0`.
- ERROR response on a read by `req[0]` → `done=0001`, `err=1`; `ptr` advances so that `req[1]` pending wins next.
- `req[2]` dropped during BUSY → return to IDLE with no `done`; a subsequent `req[2]` is granted again.
- With `RAM_ARB_WATCHDOG_EN` and WD_CYCLES=8, `ramstate` stuck BUSY → `done` with `err=1` after 8 ISSUE cycles. Mid-ISSUE `RST` pulse → all outputs 0 in the same cycle.
